compl_queue: RTL and testbench
==============================

COMPL_QUEUE -- requirements
Module: compl_queue

Interface
REQ-001 Parameter ADDRW, default 24, address width, shall match the serializer's ADDRW.
REQ-002 Parameter DEPTH, default 4, FIFO entries, power of two, >= 2.
REQ-003 Parameter MAX_RETRY, default 3, retransmissions allowed per entry (used only with retry compiled in).
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 push_valid  input  1  request side offers an address.
REQ-007 push_addr  input  ADDRW  address to enqueue.
REQ-008 push_ready  output  1  queue can accept; equals !full (registered state).
REQ-009 valid_out  output  1  head entry offered to the serializer (drives its valid_in).
REQ-010 addr_out  output  ADDRW  head entry address (drives its addr).
REQ-011 ser_ready  input  1  serializer ready_out, synchronous to clk.
REQ-012 ser_err  input  1  serializer err flag, synchronous to clk.
REQ-013 count  output  clog2(DEPTH+1)  entries held, including the entry in flight.
REQ-014 drop_err  output  1  one-cycle pulse when an entry is discarded after exhausting retries.

Function
REQ-015 Push shall occur on a clk edge with push_valid && push_ready; the entry is written at the tail and count increments.
REQ-016 Push while full shall be ignored; no state change, no overwrite.
REQ-017 Same-cycle push and pop shall leave count unchanged; when full, push_ready=0, so the push is rejected even if a pop occurs that cycle.
REQ-018 Pointers shall wrap modulo DEPTH; full = (count==DEPTH), empty = (count==0).
REQ-019 FSM states: IDLE, OFFER, BUSY; valid_out=1 only in OFFER; addr_out shall always equal the head entry.
REQ-020 IDLE->OFFER when count!=0 && ser_ready==1.
REQ-021 OFFER->BUSY on the first cycle ser_ready==0 (serializer accepted); valid_out shall be 0 from the following cycle.
REQ-022 BUSY->IDLE on the first cycle ser_ready==1; the completion action (pop or retry) takes effect on that edge.
REQ-023 Latency: push at edge N into an empty queue with ser_ready=1 and FSM in IDLE shall give count=1 after N and valid_out=1 after N+1.
REQ-024 Head entry and addr_out shall not change while in OFFER or BUSY.
REQ-025 ser_err asserted outside BUSY shall be ignored.

Reset
REQ-026 rst asserted shall immediately force: state IDLE, pointers 0, count=0, push_ready=1, valid_out=0, drop_err=0, retry counter 0; storage contents are don't-care.
REQ-027 rst asserted mid-transfer (OFFER/BUSY) shall discard all entries, including the in-flight one, with no drop_err pulse.

Configuration
REQ-028 Macro COMPL_QUEUE_RETRY_EN shall select the retransmission feature.
REQ-029 With COMPL_QUEUE_RETRY_EN defined: on BUSY->IDLE with ser_err==1 and retry counter < MAX_RETRY, the head entry shall be kept and the retry counter incremented.
REQ-030 With COMPL_QUEUE_RETRY_EN defined: on BUSY->IDLE with ser_err==1 and retry counter == MAX_RETRY, the head entry shall be popped, drop_err pulsed for one cycle, and the retry counter cleared.
REQ-031 With COMPL_QUEUE_RETRY_EN defined: on BUSY->IDLE with ser_err==0, the head entry shall be popped and the retry counter cleared.
REQ-032 Without COMPL_QUEUE_RETRY_EN: the pop shall occur on OFFER->BUSY, ser_err shall be ignored, drop_err shall be tied to 0, and MAX_RETRY and the retry counter shall be unused.

Verification
REQ-033 Push 0x123456, 0xABCDEF with ser_ready=1 -> valid_out=1, addr_out=0x123456 two cycles after the first push; after the ser_ready 1->0->1 sequence, addr_out=0xABCDEF and count=1.
REQ-034 Push 5 entries with DEPTH=4 and ser_ready held 0 -> push_ready=0 after the 4th push, the 5th is dropped, count=4, and the FIFO order of the 4 entries is preserved.
REQ-035 RETRY_EN, MAX_RETRY=3, head 0x000010, ser_err=1 on each completion -> 4 offers of 0x000010, then drop_err pulses once and count decrements.
REQ-036 RETRY_EN, ser_err=1 on the first completion only -> 0x000010 offered twice, popped after the second transfer, drop_err stays 0.
REQ-037 rst pulse while in BUSY with count=3 -> count=0, valid_out=0, push_ready=1 immediately; the next push of 0x000001 is offered normally.
REQ-038 Full queue with simultaneous push_valid and a completing pop -> push rejected, count=3.

Source files
------------

// File: rtl/compl_queue.sv
// compl_queue: address FIFO that hands its head entry to a serializer, one transfer at a time.
// Optional retransmission on serializer error is built when COMPL_QUEUE_RETRY_EN is defined.
module compl_queue #(
    parameter int ADDRW     = 24,
    parameter int DEPTH     = 4,
    parameter int MAX_RETRY = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_valid,
    input  logic [ADDRW-1:0]           push_addr,
    output logic                       push_ready,
    output logic                       valid_out,
    output logic [ADDRW-1:0]           addr_out,
    input  logic                       ser_ready,
    input  logic                       ser_err,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       drop_err
);
    localparam int PTRW = $clog2(DEPTH);
    localparam int CNTW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, OFFER, BUSY} state_t;

    state_t           state_reg, state_next;
    logic [PTRW-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [CNTW-1:0]  count_reg, count_next;
    logic [ADDRW-1:0] mem [DEPTH];
    logic             full, empty, push_fire, pop;

    assign full       = (count_reg == CNTW'(DEPTH));
    assign empty      = (count_reg == '0);
    assign push_ready = !full;
    assign push_fire  = push_valid && !full;
    assign valid_out  = (state_reg == OFFER);
    assign addr_out   = mem[rd_ptr_reg];
    assign count      = count_reg;

    // Storage is never reset; only the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (push_fire) begin
            mem[wr_ptr_reg] <= push_addr;
        end
    end

`ifdef COMPL_QUEUE_RETRY_EN
    localparam int RTRW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    logic [RTRW-1:0] retry_reg, retry_next;
    logic            drop_reg, drop_next;

    assign drop_err = drop_reg;
`else
    logic unused_ser_err;
    localparam int unused_max_retry = MAX_RETRY;

    assign unused_ser_err = ser_err;
    assign drop_err       = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        pop        = 1'b0;
`ifdef COMPL_QUEUE_RETRY_EN
        retry_next = retry_reg;
        drop_next  = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                if (!empty && ser_ready) begin
                    state_next = OFFER;
                end
            end
            OFFER: begin
                // ser_ready dropping means the serializer has latched addr_out.
                if (!ser_ready) begin
                    state_next = BUSY;
`ifndef COMPL_QUEUE_RETRY_EN
                    pop        = 1'b1;
`endif
                end
            end
            BUSY: begin
                if (ser_ready) begin
                    state_next = IDLE;
`ifdef COMPL_QUEUE_RETRY_EN
                    // Failed transfer keeps the head until its retry budget is spent.
                    if (ser_err && (retry_reg < RTRW'(MAX_RETRY))) begin
                        retry_next = retry_reg + RTRW'(1);
                    end else begin
                        pop        = 1'b1;
                        retry_next = '0;
                        drop_next  = ser_err;
                    end
`endif
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        count_next = count_reg;
        case ({push_fire, pop})
            2'b10:   count_next = count_reg + CNTW'(1);
            2'b01:   count_next = count_reg - CNTW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            if (push_fire) begin
                wr_ptr_reg <= wr_ptr_reg + PTRW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTRW'(1);
            end
        end
    end

`ifdef COMPL_QUEUE_RETRY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retry_reg <= '0;
            drop_reg  <= 1'b0;
        end else begin
            retry_reg <= retry_next;
            drop_reg  <= drop_next;
        end
    end
`endif

endmodule

// File: tb/tb_compl_queue.sv
// Directed testbench for compl_queue (DEPTH=4, ADDRW=24, MAX_RETRY=3); covers both builds.
module tb_compl_queue;
    logic        clk = 1'b0;
    logic        rst;
    logic        push_valid;
    logic [23:0] push_addr;
    logic        push_ready;
    logic        valid_out;
    logic [23:0] addr_out;
    logic        ser_ready;
    logic        ser_err;
    logic [2:0]  count;
    logic        drop_err;

    int n_pass  = 0;
    int n_total = 0;

    compl_queue #(.ADDRW(24), .DEPTH(4), .MAX_RETRY(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .push_valid (push_valid),
        .push_addr  (push_addr),
        .push_ready (push_ready),
        .valid_out  (valid_out),
        .addr_out   (addr_out),
        .ser_ready  (ser_ready),
        .ser_err    (ser_err),
        .count      (count),
        .drop_err   (drop_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called while in OFFER: serializer accepts, then completes with the given error flag.
    task automatic complete(input logic err);
        ser_ready = 1'b0;
        tick();
        ser_err   = err;
        ser_ready = 1'b1;
        tick();
        ser_err   = 1'b0;
    endtask

    task automatic push_one(input logic [23:0] a);
        push_valid = 1'b1;
        push_addr  = a;
        tick();
        push_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; push_valid = 1'b0; push_addr = '0; ser_ready = 1'b1; ser_err = 1'b0;
        #2;
        n_total++; if (count !== 3'd0) $display("FAIL reset_count got %0d want 0", count); else n_pass++;
        n_total++; if (push_ready !== 1'b1) $display("FAIL reset_push_ready got %b want 1", push_ready); else n_pass++;
        n_total++; if (valid_out !== 1'b0) $display("FAIL reset_valid_out got %b want 0", valid_out); else n_pass++;
        n_total++; if (drop_err !== 1'b0) $display("FAIL reset_drop_err got %b want 0", drop_err); else n_pass++;
        tick();
        rst = 1'b0;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_basic();
        push_valid = 1'b1; push_addr = 24'h123456;
        tick();
        n_total++; if (count !== 3'd1) $display("FAIL basic_count1 got %0d want 1", count); else n_pass++;
        n_total++; if (valid_out !== 1'b0) $display("FAIL basic_valid_early got %b want 0", valid_out); else n_pass++;
        push_addr = 24'hABCDEF;
        tick();
        push_valid = 1'b0;
        n_total++; if (valid_out !== 1'b1) $display("FAIL basic_valid got %b want 1", valid_out); else n_pass++;
        n_total++; if (addr_out !== 24'h123456) $display("FAIL basic_addr1 got %h want 123456", addr_out); else n_pass++;
        ser_ready = 1'b0;
        tick();
        n_total++; if (valid_out !== 1'b0) $display("FAIL basic_valid_busy got %b want 0", valid_out); else n_pass++;
        ser_ready = 1'b1;
        tick();
        n_total++; if (addr_out !== 24'hABCDEF) $display("FAIL basic_addr2 got %h want abcdef", addr_out); else n_pass++;
        n_total++; if (count !== 3'd1) $display("FAIL basic_count_after got %0d want 1", count); else n_pass++;
        tick();
        complete(1'b0);
        n_total++; if (count !== 3'd0) $display("FAIL basic_drained got %0d want 0", count); else n_pass++;
        $display("test_basic done");
    endtask

    task automatic test_full();
        logic [23:0] vals [5];
        vals[0] = 24'hA00001; vals[1] = 24'hA00002; vals[2] = 24'hA00003;
        vals[3] = 24'hA00004; vals[4] = 24'hA00005;
        ser_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push_one(vals[i]);
            if (i == 3) begin
                n_total++; if (push_ready !== 1'b0) $display("FAIL full_push_ready got %b want 0", push_ready); else n_pass++;
            end
        end
        n_total++; if (count !== 3'd4) $display("FAIL full_count got %0d want 4", count); else n_pass++;
        ser_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_total++;
            if (valid_out !== 1'b1 || addr_out !== vals[i])
                $display("FAIL full_order%0d got v=%b a=%h want v=1 a=%h", i, valid_out, addr_out, vals[i]);
            else n_pass++;
            complete(1'b0);
        end
        n_total++; if (count !== 3'd0) $display("FAIL full_drained got %0d want 0", count); else n_pass++;
        $display("test_full done");
    endtask

    task automatic test_full_pop();
        ser_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_one(24'hB00000 + 24'(i));
        ser_ready = 1'b1;
        tick();
        push_addr = 24'hEEEEEE;
`ifdef COMPL_QUEUE_RETRY_EN
        ser_ready = 1'b0;
        tick();
        push_valid = 1'b1;
        ser_ready  = 1'b1;
        tick();
`else
        push_valid = 1'b1;
        ser_ready  = 1'b0;
        tick();
`endif
        push_valid = 1'b0;
        n_total++; if (count !== 3'd3) $display("FAIL fullpop_count got %0d want 3", count); else n_pass++;
        n_total++; if (addr_out !== 24'hB00001) $display("FAIL fullpop_head got %h want b00001", addr_out); else n_pass++;
        $display("test_full_pop done");
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ser_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_one(24'hC00000 + 24'(i));
        ser_ready = 1'b1;
        tick();
        ser_ready = 1'b0;
        tick();
        rst = 1'b1;
        #2;
        n_total++; if (count !== 3'd0) $display("FAIL rstmid_count got %0d want 0", count); else n_pass++;
        n_total++; if (valid_out !== 1'b0) $display("FAIL rstmid_valid got %b want 0", valid_out); else n_pass++;
        n_total++; if (push_ready !== 1'b1) $display("FAIL rstmid_push_ready got %b want 1", push_ready); else n_pass++;
        rst = 1'b0;
        ser_ready = 1'b1;
        tick();
        push_one(24'h000001);
        n_total++; if (count !== 3'd1) $display("FAIL rstmid_count1 got %0d want 1", count); else n_pass++;
        tick();
        n_total++;
        if (valid_out !== 1'b1 || addr_out !== 24'h000001)
            $display("FAIL rstmid_offer got v=%b a=%h want v=1 a=000001", valid_out, addr_out);
        else n_pass++;
        complete(1'b0);
        n_total++; if (drop_err !== 1'b0) $display("FAIL rstmid_drop got %b want 0", drop_err); else n_pass++;
        $display("test_reset_mid done");
    endtask

`ifdef COMPL_QUEUE_RETRY_EN
    task automatic test_retry_exhaust();
        ser_ready = 1'b1;
        push_one(24'h000010);
        for (int i = 0; i < 4; i++) begin
            tick();
            n_total++;
            if (valid_out !== 1'b1 || addr_out !== 24'h000010)
                $display("FAIL retry_offer%0d got v=%b a=%h want v=1 a=000010", i, valid_out, addr_out);
            else n_pass++;
            complete(1'b1);
            n_total++;
            if (drop_err !== (i == 3) || count !== ((i == 3) ? 3'd0 : 3'd1))
                $display("FAIL retry_state%0d got drop=%b cnt=%0d want drop=%b cnt=%0d",
                         i, drop_err, count, (i == 3), (i == 3) ? 0 : 1);
            else n_pass++;
        end
        tick();
        n_total++; if (drop_err !== 1'b0) $display("FAIL retry_pulse_len got %b want 0", drop_err); else n_pass++;
        n_total++; if (valid_out !== 1'b0) $display("FAIL retry_empty_valid got %b want 0", valid_out); else n_pass++;
        $display("test_retry_exhaust done");
    endtask

    task automatic test_retry_once();
        push_one(24'h000010);
        for (int i = 0; i < 2; i++) begin
            tick();
            n_total++;
            if (valid_out !== 1'b1 || addr_out !== 24'h000010)
                $display("FAIL once_offer%0d got v=%b a=%h want v=1 a=000010", i, valid_out, addr_out);
            else n_pass++;
            complete(i == 0);
            n_total++;
            if (drop_err !== 1'b0 || count !== ((i == 0) ? 3'd1 : 3'd0))
                $display("FAIL once_state%0d got drop=%b cnt=%0d want drop=0 cnt=%0d",
                         i, drop_err, count, (i == 0) ? 1 : 0);
            else n_pass++;
        end
        tick();
        n_total++; if (valid_out !== 1'b0) $display("FAIL once_empty_valid got %b want 0", valid_out); else n_pass++;
        $display("test_retry_once done");
    endtask
`else
    task automatic test_err_ignored();
        ser_ready = 1'b1;
        push_one(24'h000010);
        tick();
        complete(1'b1);
        n_total++; if (count !== 3'd0) $display("FAIL errign_count got %0d want 0", count); else n_pass++;
        n_total++; if (drop_err !== 1'b0) $display("FAIL errign_drop got %b want 0", drop_err); else n_pass++;
        tick();
        n_total++; if (valid_out !== 1'b0) $display("FAIL errign_valid got %b want 0", valid_out); else n_pass++;
        $display("test_err_ignored done");
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_full_pop();
        test_reset_mid();
`ifdef COMPL_QUEUE_RETRY_EN
        test_retry_exhaust();
        test_retry_once();
`else
        test_err_ignored();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
